ccc_reconfig_ctrl: RTL and testbench

//  Sequencer for the fabric CCC/PLL: runs PLL reset, APB dynamic-config writes and lock qualification.

---
 rtl/ccc_ctrl_pkg.sv | 19 +
 rtl/ccc_lock_sync.sv | 25 ++
 rtl/ccc_reconfig_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ccc_reconfig_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccc_ctrl_pkg.sv
// Shared types and CCC APB widths for the CCC/PLL reconfiguration controller.
package ccc_ctrl_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_PLL_RST   = 4'd1,
    ST_WAIT_BUSY = 4'd2,
    ST_SETUP     = 4'd3,
    ST_ACCESS    = 4'd4,
    ST_RELEASE   = 4'd5,
    ST_WAIT_LOCK = 4'd6,
    ST_LOCKED    = 4'd7,
    ST_FAIL      = 4'd8
  } state_e;

endpackage

// File: rtl/ccc_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous CCC LOCK into the PCLK domain.
module ccc_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; output is the second stage only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ccc_reconfig_ctrl.sv
// CCC/PLL sequencer: PLL reset, APB table write into the CCC, lock qualification,
// runtime lock supervision and bounded retry on lock timeout.
module ccc_reconfig_ctrl
  import ccc_ctrl_pkg::*;
#(
  parameter  int NUM_REGS     = 8,
  parameter  int RST_CYCLES   = 16,
  parameter  int LOCK_STABLE  = 256,
  parameter  int LOCK_TIMEOUT = 65535,
  parameter  int MAX_RETRY    = 3,
  localparam int IDX_W        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              recfg_req,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic              ccc_lock,
  input  logic              ccc_busy,
  output logic              ccc_psel,
  output logic              ccc_penable,
  output logic              ccc_pwrite,
  output logic [ADDR_W-1:0] ccc_paddr,
  output logic [DATA_W-1:0] ccc_pwdata,
  output logic              pll_arst_n,
  output logic              clk_ok,
  output logic              fab_rst_n,
  output logic              busy,
  output logic              lock_lost,
  output logic              fail
);

  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(LOCK_TIMEOUT);
  localparam logic [RTY_W-1:0]  RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [IDX_W-1:0]  tbl_idx_q, tbl_idx_d;
  logic              write_tbl_q, write_tbl_d;
  logic              lock_lost_q, lock_lost_d;
  logic              clk_ok_q, clk_ok_d;
  logic              fab_rst_n_q, fab_rst_n_d;
  logic              lock_s;
  logic              recfg_ok;

  ccc_lock_sync u_lock_sync (
    .clk   (PCLK),
    .rst_n (PRESET_N),
    .d     (ccc_lock),
    .q     (lock_s)
  );

  assign recfg_ok = recfg_req && ((state_q == ST_LOCKED) || (state_q == ST_FAIL));

  // Next-state, counters and sticky flags; counters idle at zero outside their state.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = '0;
    stab_d      = '0;
    to_d        = '0;
    retry_d     = retry_q;
    tbl_idx_d   = tbl_idx_q;
    write_tbl_d = write_tbl_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      ST_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = write_tbl_q ? ST_WAIT_BUSY : ST_RELEASE;
        else                       rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_WAIT_BUSY: if (!ccc_busy) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (tbl_idx_q == IDX_LAST) begin
          tbl_idx_d = '0;
          state_d   = ST_RELEASE;
        end else begin
          tbl_idx_d = tbl_idx_q + 1'b1;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_RELEASE:   state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        // A LOCK glitch restarts stability; the timeout keeps counting.
        stab_d = !lock_s ? '0 : ((stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1);
        to_d   = (to_q == TO_MAX) ? to_q : to_q + 1'b1;
        if (stab_q == STAB_MAX) begin
          state_d = ST_LOCKED;
        end else if (to_q == TO_MAX) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_PLL_RST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = ST_WAIT_LOCK;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      ST_IDLE: state_d = ST_IDLE;
      default: state_d = ST_PLL_RST;
    endcase
    if (recfg_ok) begin
      write_tbl_d = 1'b1;
      retry_d     = '0;
      tbl_idx_d   = '0;
      lock_lost_d = 1'b0;
      state_d     = ST_PLL_RST;
    end
    clk_ok_d    = (state_d == ST_LOCKED);
    fab_rst_n_d = (state_d == ST_LOCKED);
  end

  // State and datapath registers; reset lands in PLL_RST with the table skipped.
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q     <= ST_PLL_RST;
      rst_cnt_q   <= '0;
      stab_q      <= '0;
      to_q        <= '0;
      retry_q     <= '0;
      tbl_idx_q   <= '0;
      write_tbl_q <= 1'b0;
      lock_lost_q <= 1'b0;
      clk_ok_q    <= 1'b0;
      fab_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stab_q      <= stab_d;
      to_q        <= to_d;
      retry_q     <= retry_d;
      tbl_idx_q   <= tbl_idx_d;
      write_tbl_q <= write_tbl_d;
      lock_lost_q <= lock_lost_d;
      clk_ok_q    <= clk_ok_d;
      fab_rst_n_q <= fab_rst_n_d;
    end
  end

  // APB outputs decode straight from the state so reset drops them immediately.
  assign ccc_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign ccc_penable = (state_q == ST_ACCESS);
  assign ccc_pwrite  = ccc_psel;
  assign ccc_paddr   = ccc_psel ? tbl_addr : '0;
  assign ccc_pwdata  = ccc_psel ? tbl_data : '0;
  assign tbl_idx     = tbl_idx_q;

  assign pll_arst_n = !((state_q == ST_PLL_RST) || (state_q == ST_WAIT_BUSY) ||
                        (state_q == ST_SETUP)   || (state_q == ST_ACCESS));
  assign busy       = !((state_q == ST_IDLE) || (state_q == ST_LOCKED) || (state_q == ST_FAIL));
  assign fail       = (state_q == ST_FAIL);
  assign clk_ok     = clk_ok_q;
  assign fab_rst_n  = fab_rst_n_q;
  assign lock_lost  = lock_lost_q;

endmodule

// File: tb/tb_ccc_reconfig_ctrl.sv
// Directed bench for ccc_reconfig_ctrl with a shortened lock timeout.
module tb_ccc_reconfig_ctrl;

  localparam int TO = 400;

  logic       PCLK = 1'b0;
  logic       PRESET_N = 1'b0;
  logic       recfg_req = 1'b0;
  logic [2:0] tbl_idx;
  logic [5:0] tbl_addr;
  logic [7:0] tbl_data;
  logic       ccc_lock = 1'b0;
  logic       ccc_busy = 1'b0;
  logic       ccc_psel, ccc_penable, ccc_pwrite;
  logic [5:0] ccc_paddr;
  logic [7:0] ccc_pwdata;
  logic       pll_arst_n, clk_ok, fab_rst_n, busy, lock_lost, fail;

  int n_cmp = 0;
  int n_err = 0;

  int n_setup = 0;
  int bad_wr = 0;
  logic [5:0] log_addr[$];
  logic [7:0] log_data[$];

  ccc_reconfig_ctrl #(
    .NUM_REGS(8), .RST_CYCLES(16), .LOCK_STABLE(256), .LOCK_TIMEOUT(TO), .MAX_RETRY(3)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N), .recfg_req(recfg_req), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .ccc_lock(ccc_lock), .ccc_busy(ccc_busy),
    .ccc_psel(ccc_psel), .ccc_penable(ccc_penable), .ccc_pwrite(ccc_pwrite),
    .ccc_paddr(ccc_paddr), .ccc_pwdata(ccc_pwdata), .pll_arst_n(pll_arst_n),
    .clk_ok(clk_ok), .fab_rst_n(fab_rst_n), .busy(busy), .lock_lost(lock_lost), .fail(fail)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [5:0] tab_addr(input int i);
    case (i)
      0: return 6'h03; 1: return 6'h07; 2: return 6'h0C; 3: return 6'h11;
      4: return 6'h1F; 5: return 6'h22; 6: return 6'h2A; default: return 6'h3F;
    endcase
  endfunction

  function automatic logic [7:0] tab_data(input int i);
    case (i)
      0: return 8'hA5; 1: return 8'h5A; 2: return 8'h01; 3: return 8'hFE;
      4: return 8'h37; 5: return 8'hC8; 6: return 8'h80; default: return 8'h7F;
    endcase
  endfunction

  always_comb begin
    tbl_addr = tab_addr(int'(tbl_idx));
    tbl_data = tab_data(int'(tbl_idx));
  end

  // APB observer: logs every ACCESS phase and counts SETUP phases.
  always @(negedge PCLK) begin
    if (PRESET_N) begin
      if (ccc_psel && !ccc_pwrite) bad_wr++;
      if (ccc_psel && !ccc_penable) n_setup++;
      if (ccc_psel && ccc_penable) begin
        log_addr.push_back(ccc_paddr);
        log_data.push_back(ccc_pwdata);
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    n_setup = 0;
    bad_wr  = 0;
  endtask

  task automatic wait_pll_rise(input int bound, output int n, output bit ok);
    logic prev;
    prev = pll_arst_n;
    n = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(posedge PCLK);
      n++;
      #1;
      if (!prev && pll_arst_n) begin
        ok = 1'b1;
        break;
      end
      prev = pll_arst_n;
    end
  endtask

  task automatic wait_clk_ok(input int bound, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < bound) begin
      @(posedge PCLK);
      n++;
      #1;
      if (clk_ok) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_recfg();
    @(negedge PCLK);
    recfg_req = 1'b1;
    @(negedge PCLK);
    recfg_req = 1'b0;
  endtask

  task automatic test_reset();
    PRESET_N = 1'b0;
    repeat (3) @(negedge PCLK);
    n_cmp++;
    if ({pll_arst_n, ccc_psel, ccc_penable, ccc_pwrite} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_ctl got arst/psel/pen/pwr=%b want 0000",
               {pll_arst_n, ccc_psel, ccc_penable, ccc_pwrite});
    end
    n_cmp++;
    if ({ccc_paddr, ccc_pwdata, tbl_idx} !== 17'h0) begin
      n_err++;
      $display("FAIL reset_bus got addr=%h data=%h idx=%0d want 0", ccc_paddr, ccc_pwdata, tbl_idx);
    end
    n_cmp++;
    if ({clk_ok, fab_rst_n, busy, lock_lost, fail} !== 5'b00100) begin
      n_err++;
      $display("FAIL reset_status got ok/frst/busy/lost/fail=%b want 00100",
               {clk_ok, fab_rst_n, busy, lock_lost, fail});
    end
  endtask

  task automatic test_startup();
    int n, m;
    bit ok;
    @(negedge PCLK);
    PRESET_N = 1'b1;
    clear_log();
    wait_pll_rise(100, n, ok);
    n_cmp++;
    if (!ok || n != 16) begin
      n_err++;
      $display("FAIL startup_rst_len got %0d cycles (ok=%0d) want 16", n, ok);
    end
    repeat (10) @(posedge PCLK);
    #1 ccc_lock = 1'b1;
    wait_clk_ok(400, m, ok);
    n_cmp++;
    if (!ok || (m + 10) != 269) begin
      n_err++;
      $display("FAIL startup_lock_time got %0d want 269", m + 10);
    end
    n_cmp++;
    if ({fab_rst_n, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL startup_locked got frst/busy=%b want 10", {fab_rst_n, busy});
    end
    n_cmp++;
    if (log_addr.size() != 0 || n_setup != 0) begin
      n_err++;
      $display("FAIL startup_no_apb got %0d accesses %0d setups want 0", log_addr.size(), n_setup);
    end
  endtask

  task automatic check_table(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < log_addr.size() && i < 8; i++)
      if (log_addr[i] !== tab_addr(i) || log_data[i] !== tab_data(i)) bad++;
    n_cmp++;
    if (log_addr.size() != 8 || n_setup != 8 || bad != 0 || bad_wr != 0) begin
      n_err++;
      $display("FAIL %s_table got %0d accesses %0d setups %0d wrong %0d no-pwrite want 8/8/0/0",
               tag, log_addr.size(), n_setup, bad, bad_wr);
    end
  endtask

  task automatic test_reconfig();
    int n, m;
    bit ok;
    @(negedge PCLK);
    clear_log();
    pulse_recfg();
    n_cmp++;
    if ({clk_ok, fab_rst_n, pll_arst_n, busy} !== 4'b0001) begin
      n_err++;
      $display("FAIL recfg_accept got ok/frst/arst/busy=%b want 0001",
               {clk_ok, fab_rst_n, pll_arst_n, busy});
    end
    wait_pll_rise(1000, n, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL recfg_release got timeout after %0d cycles want pll_arst_n rise", n);
    end
    check_table("recfg");
    wait_clk_ok(400, m, ok);
    n_cmp++;
    if (!ok || m != 258) begin
      n_err++;
      $display("FAIL recfg_relock got %0d want 258", m);
    end
  endtask

  task automatic test_busy_stall();
    int n, m, psel_hi;
    bit ok, found;
    @(negedge PCLK);
    clear_log();
    pulse_recfg();
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ccc_penable && tbl_idx == 3'd2) begin
        found = 1'b1;
        break;
      end
      @(negedge PCLK);
    end
    ccc_busy = 1'b1;
    psel_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (ccc_psel) psel_hi++;
      if (i == 20) recfg_req = 1'b1;
      if (i == 21) recfg_req = 1'b0;
    end
    n_cmp++;
    if (!found || psel_hi != 0 || tbl_idx !== 3'd3) begin
      n_err++;
      $display("FAIL busy_stall got found=%0d psel_cycles=%0d idx=%0d want 1/0/3", found, psel_hi, tbl_idx);
    end
    ccc_busy = 1'b0;
    wait_pll_rise(1000, n, ok);
    check_table("busy");
    wait_clk_ok(400, m, ok);
    n_cmp++;
    if (!ok || m != 258) begin
      n_err++;
      $display("FAIL busy_relock got %0d want 258", m);
    end
  endtask

  task automatic test_lock_loss();
    int k, first_low, first_high, bad;
    @(posedge PCLK);
    #1 ccc_lock = 1'b0;
    k = 0;
    first_low = -1;
    first_high = -1;
    bad = 0;
    while (k < 400) begin
      @(posedge PCLK);
      k++;
      #1;
      if (k == 5) ccc_lock = 1'b1;
      if (fab_rst_n !== clk_ok) bad++;
      if (first_low < 0 && !clk_ok) first_low = k;
      if (first_low >= 0 && clk_ok) begin
        first_high = k;
        break;
      end
    end
    n_cmp++;
    if (first_low != 3) begin
      n_err++;
      $display("FAIL lockloss_drop got %0d want 3", first_low);
    end
    n_cmp++;
    if (first_high != 264 || bad != 0) begin
      n_err++;
      $display("FAIL lockloss_relock got %0d (frst mismatches %0d) want 264/0", first_high, bad);
    end
    n_cmp++;
    if (lock_lost !== 1'b1) begin
      n_err++;
      $display("FAIL lockloss_sticky got %b want 1", lock_lost);
    end
    pulse_recfg();
    n_cmp++;
    if (lock_lost !== 1'b0) begin
      n_err++;
      $display("FAIL lockloss_clear got %b want 0", lock_lost);
    end
  endtask

  task automatic test_preset_mid_access();
    int n, m;
    bit ok, found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if (ccc_penable) begin
        found = 1'b1;
        break;
      end
    end
    PRESET_N = 1'b0;
    #1;
    n_cmp++;
    if (!found || {ccc_psel, ccc_penable, pll_arst_n} !== 3'b000 || tbl_idx !== 3'd0) begin
      n_err++;
      $display("FAIL preset_apb got found=%0d psel/pen/arst=%b idx=%0d want 1/000/0",
               found, {ccc_psel, ccc_penable, pll_arst_n}, tbl_idx);
    end
    repeat (3) @(negedge PCLK);
    PRESET_N = 1'b1;
    clear_log();
    wait_pll_rise(100, n, ok);
    n_cmp++;
    if (!ok || n != 16 || log_addr.size() != 0 || n_setup != 0) begin
      n_err++;
      $display("FAIL preset_restart got %0d cycles %0d accesses want 16/0", n, log_addr.size());
    end
    wait_clk_ok(400, m, ok);
    n_cmp++;
    if (!ok || m != 258) begin
      n_err++;
      $display("FAIL preset_relock got %0d want 258", m);
    end
  endtask

  task automatic test_timeout_fail();
    int n, m;
    bit ok;
    @(negedge PCLK);
    ccc_lock = 1'b0;
    PRESET_N = 1'b0;
    @(negedge PCLK);
    PRESET_N = 1'b1;
    clear_log();
    wait_pll_rise(100, n, ok);
    for (int a = 1; a <= 3; a++) begin
      wait_pll_rise(1000, n, ok);
      n_cmp++;
      if (!ok || n != TO + 18) begin
        n_err++;
        $display("FAIL retry_period%0d got %0d want %0d", a, n, TO + 18);
      end
    end
    m = 0;
    ok = 1'b0;
    while (m < 1000) begin
      @(posedge PCLK);
      m++;
      #1;
      if (fail) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || m != TO + 2) begin
      n_err++;
      $display("FAIL fail_time got %0d want %0d", m, TO + 2);
    end
    n_cmp++;
    if ({clk_ok, fab_rst_n, pll_arst_n, busy} !== 4'b0010 || log_addr.size() != 0) begin
      n_err++;
      $display("FAIL fail_outputs got ok/frst/arst/busy=%b accesses=%0d want 0010/0",
               {clk_ok, fab_rst_n, pll_arst_n, busy}, log_addr.size());
    end
    repeat (30) @(negedge PCLK);
    n_cmp++;
    if ({fail, pll_arst_n} !== 2'b11) begin
      n_err++;
      $display("FAIL fail_hold got fail/arst=%b want 11", {fail, pll_arst_n});
    end
    pulse_recfg();
    n_cmp++;
    if ({fail, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL fail_clear got fail/busy=%b want 01", {fail, busy});
    end
    wait_pll_rise(1000, n, ok);
    check_table("retry0");
    clear_log();
    wait_pll_rise(1000, n, ok);
    check_table("retry1");
    ccc_lock = 1'b1;
    wait_clk_ok(600, m, ok);
    n_cmp++;
    if (!ok || fail !== 1'b0) begin
      n_err++;
      $display("FAIL retry_lock got clk_ok=%0d fail=%b want 1/0", ok, fail);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_reconfig();
    test_busy_stall();
    test_lock_loss();
    test_preset_mid_access();
    test_timeout_fail();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
